mccoy_sequencer: RTL and testbench

Program sequencer for the McCoy 6-bit accumulator core.
- Holds a small program buffer, loaded one instruction per cycle over a simple valid interface.
- On command, drives the core's instruction input one instruction per clock.
- Resolves bez branches using the core's zero flag and ends the run on fall-through, halt or watchdog expiry.
- Sits between the chip I/O wrapper and the core; it replaces direct pin-driven instruction feeding.

---
 rtl/mccoy_pkg.sv | 23 ++
 rtl/mccoy_prog_mem.sv | 24 ++
 rtl/mccoy_sequencer.sv | 157 +++++++++++++++
 tb/tb_mccoy_sequencer.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mccoy_pkg.sv
// Shared definitions for the McCoy program sequencer: opcodes, instruction
// field positions and the sequencer state encoding.
package mccoy_pkg;

  localparam logic [2:0] OP_BEZ = 3'b000;
  localparam logic [2:0] OP_LI  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b011;
  localparam logic [2:0] OP_LR  = 3'b100;
  localparam logic [2:0] OP_SR  = 3'b110;

  localparam int OPC_HI = 2;
  localparam int OPC_LO = 0;
  localparam int IMM_HI = 5;
  localparam int IMM_LO = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } seq_state_t;

endpackage

// File: rtl/mccoy_prog_mem.sv
// Program buffer: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset; prog_len gates what is reachable.
module mccoy_prog_mem #(
  parameter int IW    = 6,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [IW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [IW-1:0] rdata
);

  logic [IW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mccoy_sequencer.sv
// Program sequencer for the McCoy accumulator core: loads a small program,
// then issues it one instruction per clock, resolving bez on the zero flag.
//
// state | meaning
// IDLE  | waiting for load_start / run_start
// LOAD  | accepting instructions into the buffer
// RUN   | issuing mem[pc] every cycle
// DONE  | run finished, done held until next start
module mccoy_sequencer
  import mccoy_pkg::*;
#(
  parameter int          IW         = 6,
  parameter int          DEPTH      = 8,
  parameter int          AW         = 3,
  parameter int          MAX_CYCLES = 255,
  parameter logic [IW-1:0] NOP_INSTR = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_start,
  input  logic          load_valid,
  input  logic [IW-1:0] load_data,
  input  logic          load_done,
  input  logic          run_start,
  input  logic          halt,
  input  logic          zero_flag,
  output logic [IW-1:0] instr_out,
  output logic          instr_valid,
  output logic [AW-1:0] pc,
  output logic [1:0]    state,
  output logic [AW:0]   prog_len,
  output logic          done,
  output logic          timeout,
  output logic          bad_target
);

  seq_state_t    state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   prog_len_q, prog_len_d;
  logic [7:0]    count_q, count_d;
  logic          timeout_q, timeout_d;
  logic          bad_target_q, bad_target_d;

  logic          mem_we;
  logic [IW-1:0] mem_rdata;
  logic [2:0]    opc;
  logic [AW-1:0] imm;
  logic          taken;
  logic [AW:0]   pc_inc;

  mccoy_prog_mem #(.IW(IW), .DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_ptr_q),
    .wdata (load_data),
    .raddr (pc_q),
    .rdata (mem_rdata)
  );

  assign opc    = mem_rdata[OPC_HI:OPC_LO];
  assign imm    = mem_rdata[IMM_HI:IMM_LO];
  assign taken  = (opc == OP_BEZ) && zero_flag;
  assign pc_inc = {1'b0, pc_q} + (AW+1)'(1);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    wr_ptr_d     = wr_ptr_q;
    prog_len_d   = prog_len_q;
    count_d      = count_q;
    timeout_d    = timeout_q;
    bad_target_d = bad_target_q;
    mem_we       = 1'b0;
    instr_out    = NOP_INSTR;
    instr_valid  = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (load_start) begin
          state_d      = ST_LOAD;
          wr_ptr_d     = '0;
          prog_len_d   = '0;
          timeout_d    = 1'b0;
          bad_target_d = 1'b0;
        end else if (run_start && (prog_len_q != '0)) begin
          state_d      = ST_RUN;
          pc_d         = '0;
          count_d      = '0;
          timeout_d    = 1'b0;
          bad_target_d = 1'b0;
        end
      end
      ST_LOAD: begin
        if (load_valid) begin
          mem_we     = 1'b1;
          wr_ptr_d   = wr_ptr_q + AW'(1);
          prog_len_d = prog_len_q + (AW+1)'(1);
          if ((wr_ptr_q == AW'(DEPTH - 1)) || load_done) state_d = ST_IDLE;
        end else if (load_done) begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        instr_out   = mem_rdata;
        instr_valid = 1'b1;
        count_d     = count_q + 8'd1;
        pc_d        = taken ? imm : pc_inc[AW-1:0];
        // Any terminating cycle keeps pc on the instruction just issued.
        if (halt) begin
          state_d = ST_DONE;
          pc_d    = pc_q;
        end else if (count_q == 8'(MAX_CYCLES - 1)) begin
          state_d   = ST_DONE;
          pc_d      = pc_q;
          timeout_d = 1'b1;
        end else if (taken && ({1'b0, imm} >= prog_len_q)) begin
          state_d      = ST_DONE;
          pc_d         = pc_q;
          bad_target_d = 1'b1;
        end else if (!taken && (pc_inc == prog_len_q)) begin
          state_d = ST_DONE;
          pc_d    = pc_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      pc_q         <= '0;
      wr_ptr_q     <= '0;
      prog_len_q   <= '0;
      count_q      <= '0;
      timeout_q    <= 1'b0;
      bad_target_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      wr_ptr_q     <= wr_ptr_d;
      prog_len_q   <= prog_len_d;
      count_q      <= count_d;
      timeout_q    <= timeout_d;
      bad_target_q <= bad_target_d;
    end
  end

  assign pc         = pc_q;
  assign state      = state_q;
  assign prog_len   = prog_len_q;
  assign done       = (state_q == ST_DONE);
  assign timeout    = timeout_q;
  assign bad_target = bad_target_q;

endmodule

// File: tb/tb_mccoy_sequencer.sv
// Directed bench for mccoy_sequencer: loading, straight-line runs, bez
// resolution, watchdog, halt, mid-load reset and command collisions.
module tb_mccoy_sequencer;

  logic       clk = 1'b0;
  logic       reset, load_start, load_valid, load_done, run_start, halt, zero_flag;
  logic [5:0] load_data;
  logic [5:0] instr_out;
  logic       instr_valid;
  logic [2:0] pc;
  logic [1:0] state;
  logic [3:0] prog_len;
  logic       done, timeout, bad_target;

  int n_cmp = 0;
  int n_bad = 0;

  logic [5:0] prog1 [8] = '{6'b011001, 6'b010110, 6'b100001, 6'b010100,
                            6'b000100, 6'b010011, 6'b000011, 6'b000001};
  logic [5:0] prog2 [8] = '{6'b000001, 6'b011000, 6'b100001, 6'b0, 6'b0, 6'b0, 6'b0, 6'b0};
  logic [5:0] prog3 [8] = '{6'b000001, 6'b000000, 6'b0, 6'b0, 6'b0, 6'b0, 6'b0, 6'b0};

  mccoy_sequencer dut (
    .clk(clk), .reset(reset), .load_start(load_start), .load_valid(load_valid),
    .load_data(load_data), .load_done(load_done), .run_start(run_start),
    .halt(halt), .zero_flag(zero_flag), .instr_out(instr_out),
    .instr_valid(instr_valid), .pc(pc), .state(state), .prog_len(prog_len),
    .done(done), .timeout(timeout), .bad_target(bad_target)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_prog(input logic [5:0] prog [8], input int n, input string tag);
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    n_cmp++;
    if (state !== 2'd1) begin n_bad++; $display("FAIL %s_enter_load: state=%0d expected=1", tag, state); end
    for (int i = 0; i < n; i++) begin
      load_valid = 1'b1;
      load_data  = prog[i];
      load_done  = (i == n - 1) && (n < 8);
      tick();
    end
    load_valid = 1'b0;
    load_done  = 1'b0;
    n_cmp++;
    if (state !== 2'd0) begin n_bad++; $display("FAIL %s_load_exit: state=%0d expected=0", tag, state); end
    n_cmp++;
    if (prog_len !== 4'(n)) begin n_bad++; $display("FAIL %s_prog_len: got=%0d expected=%0d", tag, prog_len, n); end
  endtask

  task automatic start_run();
    run_start = 1'b1;
    tick();
    run_start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    n_cmp++;
    if (state !== 2'd0 || pc !== 3'd0 || prog_len !== 4'd0) begin
      n_bad++; $display("FAIL reset_regs: state=%0d pc=%0d prog_len=%0d expected 0/0/0", state, pc, prog_len);
    end
    n_cmp++;
    if (done !== 1'b0 || timeout !== 1'b0 || bad_target !== 1'b0 || instr_valid !== 1'b0 || instr_out !== 6'd0) begin
      n_bad++; $display("FAIL reset_outs: done=%b timeout=%b bad=%b valid=%b instr=%b expected all 0",
                        done, timeout, bad_target, instr_valid, instr_out);
    end
    load_valid = 1'b1;
    load_data  = 6'b111111;
    tick();
    load_valid = 1'b0;
    n_cmp++;
    if (prog_len !== 4'd0 || state !== 2'd0) begin
      n_bad++; $display("FAIL idle_load_valid_ignored: prog_len=%0d state=%0d expected 0/0", prog_len, state);
    end
    start_run();
    n_cmp++;
    if (state !== 2'd0 || instr_valid !== 1'b0) begin
      n_bad++; $display("FAIL empty_run_ignored: state=%0d valid=%b expected 0/0", state, instr_valid);
    end
  endtask

  task automatic test_full_load_run();
    load_prog(prog1, 8, "full");
    start_run();
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (instr_valid !== 1'b1 || instr_out !== prog1[i] || pc !== 3'(i)) begin
        n_bad++; $display("FAIL full_issue[%0d]: valid=%b instr=%b pc=%0d expected 1/%b/%0d",
                          i, instr_valid, instr_out, pc, prog1[i], i);
      end
      tick();
    end
    n_cmp++;
    if (done !== 1'b1 || state !== 2'd3 || instr_valid !== 1'b0 || instr_out !== 6'd0 || pc !== 3'd7) begin
      n_bad++; $display("FAIL full_done: done=%b state=%0d valid=%b instr=%b pc=%0d expected 1/3/0/000000/7",
                        done, state, instr_valid, instr_out, pc);
    end
  endtask

  task automatic test_branch();
    logic [5:0] exp_seq [3] = '{6'b000001, 6'b011000, 6'b100001};
    load_prog(prog2, 3, "br");
    zero_flag = 1'b0;
    start_run();
    for (int i = 0; i < 2; i++) begin
      zero_flag = (i == 1);
      n_cmp++;
      if (instr_valid !== 1'b1 || instr_out !== exp_seq[i] || pc !== 3'(i)) begin
        n_bad++; $display("FAIL br_taken_issue[%0d]: valid=%b instr=%b pc=%0d expected 1/%b/%0d",
                          i, instr_valid, instr_out, pc, exp_seq[i], i);
      end
      tick();
    end
    zero_flag = 1'b0;
    n_cmp++;
    if (state !== 2'd3 || bad_target !== 1'b1 || timeout !== 1'b0 || pc !== 3'd1) begin
      n_bad++; $display("FAIL br_bad_target: state=%0d bad=%b timeout=%b pc=%0d expected 3/1/0/1",
                        state, bad_target, timeout, pc);
    end
    start_run();
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (instr_valid !== 1'b1 || instr_out !== exp_seq[i] || pc !== 3'(i)) begin
        n_bad++; $display("FAIL br_fall_issue[%0d]: valid=%b instr=%b pc=%0d expected 1/%b/%0d",
                          i, instr_valid, instr_out, pc, exp_seq[i], i);
      end
      tick();
    end
    n_cmp++;
    if (done !== 1'b1 || bad_target !== 1'b0 || instr_valid !== 1'b0 || pc !== 3'd2) begin
      n_bad++; $display("FAIL br_fall_done: done=%b bad=%b valid=%b pc=%0d expected 1/0/0/2",
                        done, bad_target, instr_valid, pc);
    end
  endtask

  task automatic test_watchdog();
    int issued = 0;
    int cyc = 0;
    int pc_errs = 0;
    load_prog(prog3, 2, "wd");
    zero_flag = 1'b1;
    start_run();
    while (state === 2'd2 && cyc < 400) begin
      if (instr_valid === 1'b1) issued++;
      if (pc !== 3'(cyc % 2)) pc_errs++;
      cyc++;
      tick();
    end
    zero_flag = 1'b0;
    n_cmp++;
    if (cyc >= 400) begin n_bad++; $display("FAIL wd_bound: run still active after %0d cycles expected end at 255", cyc); end
    n_cmp++;
    if (issued !== 255) begin n_bad++; $display("FAIL wd_issued: got=%0d expected=255", issued); end
    n_cmp++;
    if (pc_errs !== 0) begin n_bad++; $display("FAIL wd_pc_alternate: %0d cycles with wrong pc expected 0", pc_errs); end
    n_cmp++;
    if (done !== 1'b1 || timeout !== 1'b1 || bad_target !== 1'b0 || pc !== 3'd0) begin
      n_bad++; $display("FAIL wd_flags: done=%b timeout=%b bad=%b pc=%0d expected 1/1/0/0",
                        done, timeout, bad_target, pc);
    end
  endtask

  task automatic test_halt();
    load_prog(prog1, 8, "halt");
    start_run();
    tick();
    tick();
    halt = 1'b1;
    n_cmp++;
    if (instr_valid !== 1'b1 || instr_out !== 6'b100001 || pc !== 3'd2) begin
      n_bad++; $display("FAIL halt_issue: valid=%b instr=%b pc=%0d expected 1/100001/2", instr_valid, instr_out, pc);
    end
    tick();
    halt = 1'b0;
    n_cmp++;
    if (state !== 2'd3 || pc !== 3'd2 || instr_valid !== 1'b0 || timeout !== 1'b0) begin
      n_bad++; $display("FAIL halt_done: state=%0d pc=%0d valid=%b timeout=%b expected 3/2/0/0",
                        state, pc, instr_valid, timeout);
    end
    tick();
    n_cmp++;
    if (state !== 2'd3 || pc !== 3'd2 || done !== 1'b1) begin
      n_bad++; $display("FAIL halt_hold: state=%0d pc=%0d done=%b expected 3/2/1", state, pc, done);
    end
  endtask

  task automatic test_load_run_collision();
    load_start = 1'b1;
    run_start  = 1'b1;
    tick();
    load_start = 1'b0;
    run_start  = 1'b0;
    n_cmp++;
    if (state !== 2'd1 || done !== 1'b0 || prog_len !== 4'd0 || instr_valid !== 1'b0) begin
      n_bad++; $display("FAIL collide_load_wins: state=%0d done=%b prog_len=%0d valid=%b expected 1/0/0/0",
                        state, done, prog_len, instr_valid);
    end
    load_done = 1'b1;
    tick();
    load_done = 1'b0;
    n_cmp++;
    if (state !== 2'd0 || prog_len !== 4'd0) begin
      n_bad++; $display("FAIL collide_load_done: state=%0d prog_len=%0d expected 0/0", state, prog_len);
    end
  endtask

  task automatic test_reset_mid_load();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      load_valid = 1'b1;
      load_data  = prog1[i];
      tick();
    end
    load_valid = 1'b0;
    n_cmp++;
    if (state !== 2'd1 || prog_len !== 4'd3) begin
      n_bad++; $display("FAIL midload_pre: state=%0d prog_len=%0d expected 1/3", state, prog_len);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_cmp++;
    if (state !== 2'd0 || prog_len !== 4'd0 || pc !== 3'd0) begin
      n_bad++; $display("FAIL midload_reset: state=%0d prog_len=%0d pc=%0d expected 0/0/0", state, prog_len, pc);
    end
    start_run();
    n_cmp++;
    if (instr_valid !== 1'b0 || state !== 2'd0) begin
      n_bad++; $display("FAIL midload_run_ignored: valid=%b state=%0d expected 0/0", instr_valid, state);
    end
    tick();
    n_cmp++;
    if (instr_valid !== 1'b0) begin
      n_bad++; $display("FAIL midload_run_stays_idle: valid=%b expected 0", instr_valid);
    end
  endtask

  initial begin
    reset = 1'b1; load_start = 1'b0; load_valid = 1'b0; load_done = 1'b0;
    run_start = 1'b0; halt = 1'b0; zero_flag = 1'b0; load_data = 6'd0;
    test_reset();
    test_full_load_run();
    test_branch();
    test_watchdog();
    test_halt();
    test_load_run_collision();
    test_reset_mid_load();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
